uart_rx_deframer: RTL and testbench
===================================

// Module: uart_rx_deframer
// PURPOSE
//  Receive side of the board UART. Takes the asynchronous RxD pin and deframes 8N1 bytes.
//  Frame format is 8N1, or 8E1 when parity is enabled.
//  Delivers bytes through a small FIFO on a valid/ready stream.
//  Reports framing, parity and overrun errors.
//  Sits between the RxD pin and the core's receive path; runs on the PLL system clock.
// PARAMETERS
//  CLK_HZ      12_000_000  system clock frequency (Hz)
//  BAUD        115_200     line rate
//  FIFO_DEPTH  4           output FIFO entries; power of two, >=2
//  localparam CLKS_PER_BIT = (CLK_HZ + BAUD/2) / BAUD   (rounded; 104 at defaults)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  synchronous, active-high reset
//  rx         in   1  raw asynchronous serial input (idle high)
//  rx_data    out  8  FIFO head byte, LSB first on the wire
//  rx_valid   out  1  FIFO non-empty
//  rx_ready   in   1  consumer pops the head when rx_valid && rx_ready
//  frame_err  out  1  sticky: stop bit sampled low
//  par_err    out  1  sticky: parity mismatch (always 0 without UART_RX_PARITY_EN)
//  overrun    out  1  sticky: byte completed while FIFO full
//  err_clr    in   1  clears all three sticky flags
// BEHAVIOUR
//  - Reset: sync flops=1, FSM=IDLE, counters=0, FIFO empty.
//    Outputs after reset: rx_valid=0, rx_data=0, all flags=0.
//  - rx goes through a 2-FF synchronizer. All decisions use the synchronized value rxs.
//  - FSM states: IDLE, START, DATA, PARITY, STOP, BREAK. A bit counter runs 0..CLKS_PER_BIT-1.
//  - IDLE: on rxs==0 -> START; counter loads CLKS_PER_BIT/2.
//  - START: at counter expiry (mid start bit):
//      rxs==1 -> IDLE (glitch; no flag).
//      rxs==0 -> DATA, bit index 0, counter reloads CLKS_PER_BIT.
//  - DATA: sample rxs once per bit period into shift[idx], LSB first.
//      After idx 7 -> PARITY if enabled, else STOP.
//  - PARITY: sample, compare to even parity of the data byte -> STOP.
//  - STOP: sample at mid stop bit.
//      rxs==1: push byte (unless a parity error) -> IDLE.
//      rxs==0: set frame_err, discard byte -> BREAK.
//  - BREAK: wait for rxs==1, then -> IDLE. No bytes are pushed while the line is held low.
//  - Push and pop:
//      push happens in the mid-stop-sample cycle; rx_valid rises the next cycle if the FIFO was empty.
//      rx_data is show-ahead (head visible while rx_valid=1).
//      pop occurs when rx_valid && rx_ready.
//  - FIFO full at push: byte dropped, overrun=1, FIFO contents unchanged.
//    Exception: push and pop in the same cycle while full -> push accepted, no overrun.
//  - Push to empty FIFO with rx_ready=1: no bypass; the byte appears next cycle.
//  - Sticky flags: set and err_clr in the same cycle -> set wins.
//  - Receiver never stalls on consumer backpressure; only the overrun path is affected.
//  - rst asserted mid-frame: the frame is abandoned, FIFO is flushed, flags clear.
//    After reset the FSM resyncs at the next falling edge, including one occurring mid-byte.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//    Adds the PARITY state; expects an even parity bit before the stop bit.
//    On mismatch: par_err=1 and the byte is not pushed; the stop bit is still checked.
//  UART_RX_PARITY_EN undefined:
//    8N1 only; the PARITY state and its logic are absent; par_err is tied to 0.
// STRUCTURE
//  - uart_pkg (shared with the transmitter):
//      rx_state_t enum (IDLE/START/DATA/PARITY/STOP/BREAK)
//      UART_DATA_BITS=8
//      function clks_per_bit(clk_hz, baud)
//  - Sub-module uart_rx_fifo: synchronous show-ahead FIFO, FIFO_DEPTH x 8.
//      Ports: push, din, pop, dout, empty, full.
//      Pointers carry one extra wrap bit to tell full from empty.
//  - Top of this block holds: synchronizer, bit-timing counter, FSM, shifter, sticky flags.
// TESTING  (bench: CLK_HZ=1_000_000, BAUD=100_000 -> CLKS_PER_BIT=10)
//  1. Send 0xA5 as 8N1, rx_ready=1.
//     -> rx_valid pulses 1 cycle with rx_data=0xA5; no flags.
//     -> rx_valid rises within 2+1 cycles (sync + push) of the mid-stop sample.
//  2. 3-cycle low glitch on an idle line.
//     -> FSM returns to IDLE; rx_valid stays 0; no flags.
//  3. Send 0x3C with the stop bit driven low, line low for 30 bit times, then 0x55.
//     -> frame_err=1; only 0x55 is delivered.
//  4. rx_ready=0, send 0x01..0x05.
//     -> FIFO holds 0x01..0x04; overrun=1.
//     -> After rx_ready=1, pops return 0x01,0x02,0x03,0x04 in order.
//     -> err_clr clears overrun.
//  5. Parity enabled: send 0x07 with parity bit 0.
//     -> par_err=1, nothing pushed.
//     -> Same byte with parity 1 -> delivers 0x07.
//  6. Assert rst during DATA bit 4 of 0xFF, release.
//     -> rx_valid=0, flags=0; the next clean frame 0x81 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, widths and bit-timing helper
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // Rounded clocks per bit so odd ratios centre on the true bit period
    function automatic int clks_per_bit(input int clkHz, input int baud);
        return (clkHz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous show-ahead byte FIFO for the UART receiver
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty  = (wrPtr == rdPtr);
    assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    // A pop in the same cycle frees the head slot, so a full FIFO can still accept
    assign doPush = push && (!full || pop);
    assign doPop  = pop && !empty;
    assign dout   = empty ? '0 : mem[rdPtr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !rst) mem[wrPtr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - 8N1 UART receive deframer with output FIFO and sticky errors
// UART_RX_PARITY_EN adds an even parity bit (8E1) and drives par_err.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 12_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       par_err,
    output logic       overrun,
    input  logic       err_clr
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam int CW = $clog2(CLKS_PER_BIT);
    // Counter holds cycles remaining minus one; zero marks the sample point
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);

    logic                      rxMeta;
    logic                      rxs;
    rx_state_t                 state;
    rx_state_t                 stateNext;
    logic [CW-1:0]             bitCnt;
    logic [CW-1:0]             bitCntNext;
    logic [2:0]                bitIdx;
    logic [2:0]                bitIdxNext;
    logic [UART_DATA_BITS-1:0] shiftReg;
    logic [UART_DATA_BITS-1:0] shiftNext;
    logic                      expiry;
    logic                      pushReq;
    logic                      popReq;
    logic                      setFrameErr;
    logic                      fifoEmpty;
    logic                      fifoFull;
`ifdef UART_RX_PARITY_EN
    logic                      parBad;
    logic                      parBadNext;
    logic                      setParErr;
`endif

    assign expiry   = (bitCnt == '0);
    assign rx_valid = !fifoEmpty;
    assign popReq   = rx_valid && rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta   <= 1'b1;
            rxs      <= 1'b1;
            state    <= IDLE;
            bitCnt   <= '0;
            bitIdx   <= '0;
            shiftReg <= '0;
        end else begin
            rxMeta   <= rx;
            rxs      <= rxMeta;
            state    <= stateNext;
            bitCnt   <= bitCntNext;
            bitIdx   <= bitIdxNext;
            shiftReg <= shiftNext;
        end
    end

    always_comb begin
        stateNext   = state;
        bitCntNext  = expiry ? FULL_RELOAD : bitCnt - 1'b1;
        bitIdxNext  = bitIdx;
        shiftNext   = shiftReg;
        pushReq     = 1'b0;
        setFrameErr = 1'b0;
`ifdef UART_RX_PARITY_EN
        parBadNext  = parBad;
        setParErr   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rxs) begin
                    stateNext  = START;
                    bitCntNext = HALF_RELOAD;
                end
            end
            START: begin
                if (expiry) begin
                    if (rxs) begin
                        stateNext = IDLE;
                    end else begin
                        stateNext  = DATA;
                        bitIdxNext = '0;
`ifdef UART_RX_PARITY_EN
                        parBadNext = 1'b0;
`endif
                    end
                end
            end
            DATA: begin
                if (expiry) begin
                    shiftNext[bitIdx] = rxs;
                    bitIdxNext        = bitIdx + 1'b1;
                    if (bitIdx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        stateNext = PARITY;
`else
                        stateNext = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (expiry) begin
                    if (rxs != ^shiftReg) begin
                        setParErr  = 1'b1;
                        parBadNext = 1'b1;
                    end
                    stateNext = STOP;
                end
            end
`endif
            STOP: begin
                if (expiry) begin
                    if (rxs) begin
`ifdef UART_RX_PARITY_EN
                        pushReq = !parBad;
`else
                        pushReq = 1'b1;
`endif
                        stateNext = IDLE;
                    end else begin
                        setFrameErr = 1'b1;
                        stateNext   = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxs) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Sticky flags: a set in the same cycle as err_clr wins
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= setFrameErr | (frame_err & ~err_clr);
            overrun   <= (pushReq & fifoFull & ~popReq) | (overrun & ~err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
            parBad  <= 1'b0;
        end else begin
            par_err <= setParErr | (par_err & ~err_clr);
            parBad  <= parBadNext;
        end
    end
`else
    assign par_err = 1'b0;
`endif

    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(UART_DATA_BITS)
    ) fifoInst (
        .clk  (clk),
        .rst  (rst),
        .push (pushReq),
        .din  (shiftReg),
        .pop  (popReq),
        .dout (rx_data),
        .empty(fifoEmpty),
        .full (fifoFull)
    );

endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb/tb_uart_rx_deframer.sv - self-checking bench for uart_rx_deframer (10 clocks per bit)
module tb_uart_rx_deframer;

    localparam int BIT   = 10;
    localparam int DEPTH = 4;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       par_err;
    logic       overrun;
    logic       err_clr;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         validHigh = 0;
    logic [7:0] got[$];
    int         gotCyc[$];

    uart_rx_deframer #(
        .CLK_HZ(1_000_000),
        .BAUD(100_000),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .par_err  (par_err),
        .overrun  (overrun),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Consumer side: record every accepted byte and the cycle it was seen
    always @(negedge clk) begin
        if (rx_valid) validHigh++;
        if (!rst && rx_valid && rx_ready) begin
            got.push_back(rx_data);
            gotCyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Wire-level frame: start, 8 data LSB first, optional parity, stop, extra low bits, one idle bit
    task automatic send_frame(input logic [7:0] d, input bit stopBit, input int extraLow, input bit parBit);
        rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(BIT);
        end
        if (PAR_EN) begin
            rx = parBit;
            tick(BIT);
        end
        rx = stopBit;
        tick(BIT);
        if (!stopBit) tick(BIT * extraLow);
        rx = 1'b1;
        tick(BIT);
    endtask

    task automatic pulse_clear();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rx_ready = 1'b1; err_clr = 1'b0;
        tick(5);
        rst = 1'b0;
        tick(1);
        tests++;
        if (rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        tests++;
        if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", rx_data); end
        tests++;
        if ({frame_err, par_err, overrun} !== 3'b000)
            begin fails++; $display("FAIL reset_flags: got %b want 000", {frame_err, par_err, overrun}); end
    endtask

    task automatic test_single();
        int c;
        int d;
        got.delete(); gotCyc.delete(); validHigh = 0;
        c = cyc;
        send_frame(8'hA5, 1'b1, 0, ^8'hA5);
        tick(BIT);
        tests++;
        if (got.size() !== 1 || got[0] !== 8'hA5)
            begin fails++; $display("FAIL single_data: got %0d bytes first %h want 1 byte a5", got.size(), got.size() ? got[0] : 8'h00); end
        tests++;
        if (validHigh !== 1) begin fails++; $display("FAIL single_pulse: got %0d valid cycles want 1", validHigh); end
        // Wire mid-stop is 95 cycles after the start drive, i.e. posedge c+96
        d = (gotCyc.size() > 0) ? gotCyc[0] - (c + 96) : -1;
        tests++;
        if (d < 0 || d > 3) begin fails++; $display("FAIL single_latency: got %0d cycles after mid-stop want 0..3", d); end
        tests++;
        if ({frame_err, par_err, overrun} !== 3'b000)
            begin fails++; $display("FAIL single_flags: got %b want 000", {frame_err, par_err, overrun}); end
    endtask

    task automatic test_glitch();
        validHigh = 0; got.delete();
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(BIT * 20);
        tests++;
        if (validHigh !== 0) begin fails++; $display("FAIL glitch_valid: got %0d valid cycles want 0", validHigh); end
        tests++;
        if ({frame_err, par_err, overrun} !== 3'b000)
            begin fails++; $display("FAIL glitch_flags: got %b want 000", {frame_err, par_err, overrun}); end
        send_frame(8'hC3, 1'b1, 0, ^8'hC3);
        tick(BIT);
        tests++;
        if (got.size() !== 1 || got[0] !== 8'hC3)
            begin fails++; $display("FAIL glitch_recover: got %0d bytes want 1 byte c3", got.size()); end
    endtask

    task automatic test_break();
        got.delete();
        send_frame(8'h3C, 1'b0, 29, ^8'h3C);
        send_frame(8'h55, 1'b1, 0, ^8'h55);
        tick(BIT);
        tests++;
        if (frame_err !== 1'b1) begin fails++; $display("FAIL break_frame_err: got %b want 1", frame_err); end
        tests++;
        if (got.size() !== 1 || got[0] !== 8'h55)
            begin fails++; $display("FAIL break_data: got %0d bytes first %h want 1 byte 55", got.size(), got.size() ? got[0] : 8'h00); end
    endtask

    task automatic test_overrun();
        pulse_clear();
        tests++;
        if (frame_err !== 1'b0) begin fails++; $display("FAIL clear_frame_err: got %b want 0", frame_err); end
        rx_ready = 1'b0; got.delete();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, ^8'(i));
        tests++;
        if (overrun !== 1'b1) begin fails++; $display("FAIL overrun_flag: got %b want 1", overrun); end
        tests++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h01)
            begin fails++; $display("FAIL overrun_head: got valid %b data %h want 1 01", rx_valid, rx_data); end
        rx_ready = 1'b1;
        tick(BIT);
        tests++;
        if (got.size() !== 4) begin fails++; $display("FAIL overrun_count: got %0d want 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            tests++;
            if (got[i] !== 8'(i + 1)) begin fails++; $display("FAIL overrun_order: got %h want %h", got[i], 8'(i + 1)); end
        end
        pulse_clear();
        tests++;
        if (overrun !== 1'b0) begin fails++; $display("FAIL overrun_clear: got %b want 0", overrun); end
    endtask

    task automatic test_clear_priority();
        bit saw = 1'b0;
        err_clr = 1'b1;
        fork
            send_frame(8'h96, 1'b0, 0, ^8'h96);
            repeat (12 * BIT) begin
                @(negedge clk);
                if (frame_err) saw = 1'b1;
            end
        join
        tests++;
        if (saw !== 1'b1) begin fails++; $display("FAIL set_wins: got frame_err never set want set"); end
        tick(1);
        tests++;
        if (frame_err !== 1'b0) begin fails++; $display("FAIL clr_held: got %b want 0", frame_err); end
        err_clr = 1'b0;
    endtask

    task automatic test_parity();
        got.delete();
`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 0, 1'b0);
        tick(BIT);
        tests++;
        if (par_err !== 1'b1) begin fails++; $display("FAIL parity_err: got %b want 1", par_err); end
        tests++;
        if (got.size() !== 0) begin fails++; $display("FAIL parity_drop: got %0d bytes want 0", got.size()); end
        send_frame(8'h07, 1'b1, 0, 1'b1);
`else
        send_frame(8'h07, 1'b1, 0, 1'b1);
`endif
        tick(BIT);
        tests++;
        if (got.size() !== 1 || got[0] !== 8'h07)
            begin fails++; $display("FAIL parity_good: got %0d bytes want 1 byte 07", got.size()); end
        tests++;
        if (par_err !== PAR_EN) begin fails++; $display("FAIL parity_flag: got %b want %b", par_err, PAR_EN); end
        pulse_clear();
    endtask

    task automatic test_random();
        logic [7:0] expQ[$];
        logic [7:0] b;
        bit         expFrame;
        bit         bad;
        int         k;
        for (int r = 0; r < 3; r++) begin
            // Streaming round: bytes with a bad stop bit are lost and set frame_err
            pulse_clear();
            rx_ready = 1'b1; got.delete(); expQ.delete(); expFrame = 1'b0;
            for (int i = 0; i < 6; i++) begin
                b   = 8'($urandom);
                bad = ($urandom_range(0, 3) == 0);
                send_frame(b, !bad, 0, ^b);
                if (bad) expFrame = 1'b1; else expQ.push_back(b);
            end
            tick(BIT);
            tests++;
            if (got != expQ) begin fails++; $display("FAIL rand_stream: got %0d bytes want %0d", got.size(), expQ.size()); end
            tests++;
            if (frame_err !== expFrame) begin fails++; $display("FAIL rand_frame_err: got %b want %b", frame_err, expFrame); end
            // Backpressure round: only the first DEPTH bytes survive
            pulse_clear();
            rx_ready = 1'b0; got.delete(); expQ.delete();
            k = $urandom_range(1, 6);
            for (int i = 0; i < k; i++) begin
                b = 8'($urandom);
                send_frame(b, 1'b1, 0, ^b);
                if (i < DEPTH) expQ.push_back(b);
            end
            tests++;
            if (overrun !== (k > DEPTH)) begin fails++; $display("FAIL rand_overrun: got %b want %b for %0d bytes", overrun, k > DEPTH, k); end
            rx_ready = 1'b1;
            tick(BIT);
            tests++;
            if (got != expQ) begin fails++; $display("FAIL rand_burst: got %0d bytes want %0d", got.size(), expQ.size()); end
        end
        pulse_clear();
    endtask

    task automatic test_reset_midframe();
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 0, ^8'h5A);
        send_frame(8'h11, 1'b0, 0, ^8'h11);
        tests++;
        if (rx_valid !== 1'b1 || frame_err !== 1'b1)
            begin fails++; $display("FAIL pre_reset: got valid %b frame_err %b want 1 1", rx_valid, frame_err); end
        fork
            send_frame(8'hFF, 1'b1, 0, ^8'hFF);
            begin
                tick(BIT * 5 + 3);
                rst = 1'b1;
                tick(2);
                rst = 1'b0;
            end
        join
        tests++;
        if (rx_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", rx_valid); end
        tests++;
        if ({frame_err, par_err, overrun} !== 3'b000)
            begin fails++; $display("FAIL midrst_flags: got %b want 000", {frame_err, par_err, overrun}); end
        rx_ready = 1'b1; got.delete();
        send_frame(8'h81, 1'b1, 0, ^8'h81);
        tick(BIT);
        tests++;
        if (got.size() !== 1 || got[0] !== 8'h81)
            begin fails++; $display("FAIL midrst_next: got %0d bytes first %h want 1 byte 81", got.size(), got.size() ? got[0] : 8'h00); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_glitch();
        test_break();
        test_overrun();
        test_clear_priority();
        test_parity();
        test_random();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
